pwr_sw_seq: RTL and testbench

Enable sequencer for an arrayed PMOS header switch: NSEG identical PMOS segments share the switched output rail, each with its own gate bit. The block turns segments on one at a time at fixed intervals to limit inrush, turns them off in reverse order, and reports when the rail is fully on. It sits in the digital control domain beside the header array, and its gate bus drives the array's gate bits directly.

---
 rtl/pwr_sw_pkg.sv | 24 ++
 rtl/pwr_sw_step_timer.sv | 30 +++
 rtl/pwr_sw_seq.sv | 122 ++++++++++++
 tb/tb_pwr_sw_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_sw_pkg.sv
// Shared types and sizing helpers for the PMOS header-switch enable sequencer.
package pwr_sw_pkg;

    // Sequencer states: all segments off, stepping, all segments on.
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RAMP = 2'b01,
        ST_ON   = 2'b10
    } pwr_sw_state_e;

    // Width needed to count 0..nseg segments.
    function automatic int unsigned n_on_width(input int unsigned nseg);
        return $clog2(nseg + 1);
    endfunction

    // Width of the step down-counter; a 1-cycle step still needs one bit.
    function automatic int unsigned timer_width(input int unsigned step_cyc);
        if (step_cyc > 1) begin
            return $clog2(step_cyc);
        end
        return 1;
    endfunction

endpackage

// File: rtl/pwr_sw_step_timer.sv
// Loadable down-counter that flags expiry when it reaches zero.
// Clear has priority over load; the count holds at zero once expired.
module pwr_sw_step_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expire
);

    logic [Width-1:0] r_count;

    // Count register: clear, reload, or step down toward zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/pwr_sw_seq.sv
// Enable sequencer for an arrayed PMOS header switch. Segments are turned on one
// per step interval (segment 0 first) and off in reverse order to limit inrush.
module pwr_sw_seq
    import pwr_sw_pkg::*;
#(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 8
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_en_req,
    input  logic                                      i_force_off,
    output logic [NSEG-1:0]                           o_gate_n,
    output logic                                      o_en_ack,
    output logic                                      o_busy,
    output logic [pwr_sw_pkg::n_on_width(NSEG)-1:0]   o_n_on
);

    localparam int unsigned NW = n_on_width(NSEG);
    localparam int unsigned TW = timer_width(STEP_CYC);

    localparam logic [NW-1:0] NOnFull   = NW'(NSEG);
    localparam logic [NW-1:0] NOnFirst  = NW'(1);
    localparam logic [NW-1:0] NOnDown   = NW'(NSEG - 1);
    localparam logic [TW-1:0] StepLoad  = TW'(STEP_CYC - 1);

    pwr_sw_state_e   r_state;
    pwr_sw_state_e   w_state_d;
    logic [NW-1:0]   r_n_on;
    logic [NW-1:0]   w_n_on_d;
    logic [NW-1:0]   w_target;
    logic [NSEG-1:0] r_gate_n;
    logic [NSEG-1:0] w_gate_n_d;
    logic            w_load;
    logic            w_dec;
    logic            w_expire;

    pwr_sw_step_timer #(
        .Width (TW)
    ) u_step_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_force_off),
        .i_load     (w_load),
        .i_load_val (StepLoad),
        .i_dec      (w_dec),
        .o_expire   (w_expire)
    );

    assign w_dec    = (r_state == ST_RAMP);
    assign w_target = i_en_req ? NOnFull : '0;

    // Next-state logic: start a ramp from OFF/ON, step one segment per expiry in RAMP.
    always_comb begin
        w_state_d = r_state;
        w_n_on_d  = r_n_on;
        w_load    = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (i_en_req) begin
                    w_n_on_d  = NOnFirst;
                    w_load    = 1'b1;
                    w_state_d = ST_RAMP;
                end
            end
            ST_ON: begin
                if (!i_en_req) begin
                    w_n_on_d  = NOnDown;
                    w_load    = 1'b1;
                    w_state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // Direction is taken from en_req only here, so mid-interval
                // toggles never shorten the spacing between gate changes.
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_n_on < w_target) begin
                        w_n_on_d = r_n_on + NW'(1);
                    end else if (r_n_on > w_target) begin
                        w_n_on_d = r_n_on - NW'(1);
                    end else begin
                        w_state_d = i_en_req ? ST_ON : ST_OFF;
                    end
                end
            end
            default: begin
                w_state_d = ST_OFF;
                w_n_on_d  = '0;
            end
        endcase
    end

    // Thermometer decode of the next segment count: segment i on while i < n_on.
    always_comb begin
        w_gate_n_d = '1;
        for (int i = 0; i < NSEG; i++) begin
            if (i < int'(w_n_on_d)) begin
                w_gate_n_d[i] = 1'b0;
            end
        end
    end

    // State, count and gate registers; force_off behaves like reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_force_off) begin
            r_state  <= ST_OFF;
            r_n_on   <= '0;
            r_gate_n <= '1;
        end else begin
            r_state  <= w_state_d;
            r_n_on   <= w_n_on_d;
            r_gate_n <= w_gate_n_d;
        end
    end

    assign o_gate_n = r_gate_n;
    assign o_en_ack = (r_state == ST_ON);
    assign o_busy   = (r_state == ST_RAMP);
    assign o_n_on   = r_n_on;

endmodule

// File: tb/tb_pwr_sw_seq.sv
// Self-checking bench for pwr_sw_seq (NSEG = 4, STEP_CYC = 8): directed timeline
// scenarios plus a long randomized run against a timestamp-based reference model.
module tb_pwr_sw_seq;

    localparam int NSEG = 4;
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_req;
    logic       force_off;
    logic [3:0] gate_n;
    logic       en_ack;
    logic       busy;
    logic [2:0] n_on;

    int n_vec;
    int n_err;

    // Reference model: mode 0 = off, 1 = ramping, 2 = on; next_evt is the absolute
    // edge number at which the next step decision is due.
    int cyc;
    int m_mode;
    int m_n;
    int m_next;

    pwr_sw_seq #(
        .NSEG     (NSEG),
        .STEP_CYC (STEP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en_req    (en_req),
        .i_force_off (force_off),
        .o_gate_n    (gate_n),
        .o_en_ack    (en_ack),
        .o_busy      (busy),
        .o_n_on      (n_on)
    );

    always #5 clk = ~clk;

    // Expected {gate_n, en_ack, busy, n_on} for n segments on.
    function automatic logic [8:0] exp_vec(input int n, input bit ack, input bit bsy);
        logic [3:0] all1;
        logic [3:0] g;
        logic [2:0] nn;
        all1 = 4'hF;
        g    = all1 << n;
        nn   = 3'(n);
        return {g, ack, bsy, nn};
    endfunction

    function automatic logic [8:0] act_vec();
        return {gate_n, en_ack, busy, n_on};
    endfunction

    task automatic model_step();
        int tgt;
        cyc++;
        if (!rst_n || force_off) begin
            m_mode = 0;
            m_n    = 0;
        end else if (m_mode == 0) begin
            if (en_req) begin
                m_n = 1; m_mode = 1; m_next = cyc + STEP;
            end
        end else if (m_mode == 2) begin
            if (!en_req) begin
                m_n = NSEG - 1; m_mode = 1; m_next = cyc + STEP;
            end
        end else if (cyc == m_next) begin
            m_next = cyc + STEP;
            tgt    = en_req ? NSEG : 0;
            if (m_n < tgt) m_n++;
            else if (m_n > tgt) m_n--;
            else m_mode = (tgt == NSEG) ? 2 : 0;
        end
    endtask

    // One clock edge: advance the model with the inputs about to be sampled.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst_n = 1'b0; en_req = 1'b1; force_off = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = exp_vec(0, 0, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
        en_req = 1'b0; rst_n = 1'b1;
        tick();
        e = exp_vec(0, 0, 0);
        n_vec++;
        if (act_vec() !== e) begin
            n_err++;
            $display("FAIL reset_release got=%b exp=%b", act_vec(), e);
        end
    endtask

    task automatic test_ramp_up();
        logic [8:0] e;
        en_req = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            e = (k < 32) ? exp_vec(k / STEP + 1, 0, 1) : exp_vec(NSEG, 1, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL ramp_up E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    task automatic test_ramp_down();
        logic [8:0] e;
        en_req = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            tick();
            e = (k < 32) ? exp_vec(NSEG - 1 - k / STEP, 0, 1) : exp_vec(0, 0, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL ramp_down F0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    task automatic test_reversal();
        logic [8:0] e;
        int n;
        en_req = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k == 10) en_req = 1'b0;
            tick();
            n = (k < 8) ? 1 : (k < 16) ? 2 : (k < 24) ? 1 : 0;
            e = (k < 32) ? exp_vec(n, 0, 1) : exp_vec(0, 0, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL reversal E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    task automatic test_force_off();
        logic [8:0] e;
        en_req = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            tick();
            e = exp_vec(k / STEP + 1, 0, 1);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL force_pre E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
        force_off = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            e = exp_vec(0, 0, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL force_hold k=%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
        force_off = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            tick();
            e = (k < 32) ? exp_vec(k / STEP + 1, 0, 1) : exp_vec(NSEG, 1, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL force_restart E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [8:0] e;
        // Drop to OFF from ON with a one-cycle force pulse.
        en_req = 1'b0; force_off = 1'b1;
        tick();
        force_off = 1'b0;
        en_req = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            e = exp_vec(k / STEP + 1, 0, 1);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL rst_mid_pre E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
        rst_n = 1'b0;
        tick();
        e = exp_vec(0, 0, 0);
        n_vec++;
        if (act_vec() !== e) begin
            n_err++;
            $display("FAIL rst_mid_reset got=%b exp=%b", act_vec(), e);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            e = (k < 32) ? exp_vec(k / STEP + 1, 0, 1) : exp_vec(NSEG, 1, 0);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL rst_mid_restart E0+%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        rst_n = 1'b0; force_off = 1'b0; en_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) en_req = ~en_req;
            force_off = ($urandom_range(0, 149) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
            e = exp_vec(m_n, m_mode == 2, m_mode == 1);
            n_vec++;
            if (act_vec() !== e) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b exp=%b", k, act_vec(), e);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        cyc = 0; m_mode = 0; m_n = 0; m_next = 0;
        rst_n = 1'b0; en_req = 1'b0; force_off = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_force_off();
        test_reset_mid_ramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
